// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART command path.
// Holds the decoder state encoding and the default frame start marker.
// Imported by uart_cmd_decoder.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if: byte stream in from the UART receiver, register writes out.
// Ports: i_Rx_DV/i_Rx_Byte (byte strobe + byte), o_Wr_En/o_Wr_Addr/o_Wr_Data
//   (write strobe + held address/data), o_Frame_Err (error pulse), o_Busy.
// master: the side feeding bytes and observing results; slave: the decoder.
interface uart_cmd_decoder_if;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       o_Wr_En;
  logic [7:0] o_Wr_Addr;
  logic [7:0] o_Wr_Data;
  logic       o_Frame_Err;
  logic       o_Busy;

  modport master (
    output i_Rx_DV, i_Rx_Byte,
    input  o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Frame_Err, o_Busy
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte,
    output o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Frame_Err, o_Busy
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles SYNC,ADDR,DATA[,CHK] byte frames from the UART
//   receiver into one-cycle register-write strobes; flags bad checksums and
//   inter-byte timeouts with a one-cycle o_Frame_Err pulse.
// Ports: i_Clock, reset (sync, active-high), bus (uart_cmd_decoder_if.slave).
// Latency: o_Wr_En / o_Frame_Err rise the cycle after the completing byte strobe.
// Backpressure: none; the register file always accepts the write strobe.
// Config: `define UART_CMD_CHKSUM_EN for the 4-byte frame with checksum byte
//   (CHK == ADDR ^ DATA); otherwise frames are 3 bytes and errors come only
//   from timeouts.
module uart_cmd_decoder
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CLKS = 100000
) (
  input  logic                 i_Clock,
  input  logic                 reset,
  uart_cmd_decoder_if.slave    bus
);

  // A zero timeout disables the check; keep the counter at least 1 bit wide.
  localparam int              CNT_W   = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CLKS);
  localparam bit              TO_EN   = (TIMEOUT_CLKS > 0);

  state_t           r_State;
  logic [CNT_W-1:0] r_Cnt;
  logic [7:0]       r_Addr;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]       r_Data;
`endif
  logic             r_Wr_En;
  logic [7:0]       r_Wr_Addr;
  logic [7:0]       r_Wr_Data;
  logic             r_Frame_Err;

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      r_State     <= S_IDLE;
      r_Cnt       <= '0;
      r_Addr      <= 8'h00;
`ifdef UART_CMD_CHKSUM_EN
      r_Data      <= 8'h00;
`endif
      r_Wr_En     <= 1'b0;
      r_Wr_Addr   <= 8'h00;
      r_Wr_Data   <= 8'h00;
      r_Frame_Err <= 1'b0;
    end else begin
      r_Wr_En     <= 1'b0;
      r_Frame_Err <= 1'b0;

      // Gap counter only runs inside a frame; any byte restarts it.
      if (r_State == S_IDLE || bus.i_Rx_DV) begin
        r_Cnt <= '0;
      end else if (r_Cnt != CNT_MAX) begin
        r_Cnt <= r_Cnt + 1'b1;
      end

      if (bus.i_Rx_DV) begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        case (r_State)
          S_IDLE: begin
            if (bus.i_Rx_Byte == SYNC_BYTE) r_State <= S_ADDR;
          end
          S_ADDR: begin
            r_Addr  <= bus.i_Rx_Byte;
            r_State <= S_DATA;
          end
          S_DATA: begin
`ifdef UART_CMD_CHKSUM_EN
            r_Data  <= bus.i_Rx_Byte;
            r_State <= S_CHK;
`else
            r_Wr_Addr <= r_Addr;
            r_Wr_Data <= bus.i_Rx_Byte;
            r_Wr_En   <= 1'b1;
            r_State   <= S_IDLE;
`endif
          end
`ifdef UART_CMD_CHKSUM_EN
          S_CHK: begin
            if (bus.i_Rx_Byte == (r_Addr ^ r_Data)) begin
              r_Wr_Addr <= r_Addr;
              r_Wr_Data <= r_Data;
              r_Wr_En   <= 1'b1;
            end else begin
              r_Frame_Err <= 1'b1;
            end
            r_State <= S_IDLE;
          end
`endif
          default: r_State <= S_IDLE;
        endcase
      end else if (TO_EN && r_State != S_IDLE && r_Cnt == CNT_MAX) begin
        r_Frame_Err <= 1'b1;
        r_State     <= S_IDLE;
      end
    end
  end

  assign bus.o_Wr_En     = r_Wr_En;
  assign bus.o_Wr_Addr   = r_Wr_Addr;
  assign bus.o_Wr_Data   = r_Wr_Data;
  assign bus.o_Frame_Err = r_Frame_Err;
  assign bus.o_Busy      = (r_State != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: drives byte strobes into uart_cmd_decoder (timeout 50),
// predicts write/error events with a frame-level model and compares them in
// a separate negedge monitor. Works with or without UART_CMD_CHKSUM_EN.
module tb_uart_cmd_decoder;

  localparam int TO = 50;
`ifdef UART_CMD_CHKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  typedef struct {
    bit         is_err;
    logic [7:0] addr;
    logic [7:0] data;
    int         edge_n;
  } ev_t;

  logic i_Clock = 1'b0;
  logic reset   = 1'b1;
  uart_cmd_decoder_if bus();

  uart_cmd_decoder #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock (i_Clock),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 i_Clock = ~i_Clock;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge i_Clock) cyc++;

  // Reference model: frame position, bytes so far, gap since last byte.
  ev_t        exp_q[$];
  bit         exp_busy[int];
  int         m_idx = 0;
  int         m_gap = 0;
  logic [7:0] m_a = 8'h00, m_d = 8'h00, m_wa = 8'h00, m_wd = 8'h00;

  function automatic void push_ev(bit err, int e);
    ev_t ev;
    ev.is_err = err;
    ev.addr   = m_wa;
    ev.data   = m_wd;
    ev.edge_n = e;
    exp_q.push_back(ev);
  endfunction

  // One clock of stimulus; the model predicts state after the coming edge.
  task automatic step(input bit dv, input logic [7:0] b, input bit rst);
    int e;
    @(negedge i_Clock);
    bus.i_Rx_DV   = dv;
    bus.i_Rx_Byte = dv ? b : 8'($urandom);
    reset         = rst;
    e = cyc + 1;
    if (rst) begin
      m_idx = 0; m_gap = 0; m_wa = 8'h00; m_wd = 8'h00;
    end else if (dv) begin
      m_gap = 0;
      if (m_idx == 0) begin
        if (b == 8'hA5) m_idx = 1;
      end else if (m_idx == 1) begin
        m_a = b; m_idx = 2;
      end else if (m_idx == 2) begin
        m_d = b;
        if (NB == 3) begin
          m_wa = m_a; m_wd = m_d; push_ev(1'b0, e); m_idx = 0;
        end else begin
          m_idx = 3;
        end
      end else begin
        if (b == (m_a ^ m_d)) begin
          m_wa = m_a; m_wd = m_d; push_ev(1'b0, e);
        end else begin
          push_ev(1'b1, e);
        end
        m_idx = 0;
      end
    end else if (m_idx != 0) begin
      m_gap++;
      if (m_gap == TO + 1) begin
        push_ev(1'b1, e);
        m_idx = 0;
      end
    end
    exp_busy[e] = (m_idx != 0);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1'b1, b, 1'b0);
    repeat (gap) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic fail_line(input string name, input string act, input string req);
    errors++;
    $display("FAIL %s: got %s, expected %s", name, act, req);
  endtask

  // Monitor: every pulse must match the head of the expected queue, on time.
  always @(negedge i_Clock) begin
    if (!reset || exp_q.size() != 0) begin
      if (exp_busy.exists(cyc)) begin
        checks++;
        if (bus.o_Busy !== exp_busy[cyc])
          fail_line("busy", $sformatf("%b at cyc %0d", bus.o_Busy, cyc), $sformatf("%b", exp_busy[cyc]));
        exp_busy.delete(cyc);
      end
      if (bus.o_Wr_En === 1'b1 && bus.o_Frame_Err === 1'b1) begin
        checks++;
        fail_line("exclusive", "wr_en and frame_err both 1", "at most one");
      end
      if (bus.o_Wr_En === 1'b1 || bus.o_Frame_Err === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          fail_line("unexpected_pulse", $sformatf("wr=%b err=%b at cyc %0d", bus.o_Wr_En, bus.o_Frame_Err, cyc), "no pulse");
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          if (bus.o_Frame_Err !== ev.is_err || ev.edge_n != cyc ||
              bus.o_Wr_Addr !== ev.addr || bus.o_Wr_Data !== ev.data)
            fail_line("event",
              $sformatf("err=%b addr=%h data=%h cyc=%0d", bus.o_Frame_Err, bus.o_Wr_Addr, bus.o_Wr_Data, cyc),
              $sformatf("err=%b addr=%h data=%h cyc=%0d", ev.is_err, ev.addr, ev.data, ev.edge_n));
        end
      end else if (exp_q.size() != 0 && exp_q[0].edge_n < cyc) begin
        ev_t ev;
        checks++;
        ev = exp_q.pop_front();
        fail_line("missed_pulse", $sformatf("none by cyc %0d", cyc),
                  $sformatf("err=%b at cyc %0d", ev.is_err, ev.edge_n));
      end
    end
  end

  initial begin
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    repeat (3) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    @(negedge i_Clock);
    checks++;
    if (bus.o_Wr_En !== 1'b0 || bus.o_Frame_Err !== 1'b0 || bus.o_Busy !== 1'b0 ||
        bus.o_Wr_Addr !== 8'h00 || bus.o_Wr_Data !== 8'h00)
      fail_line("reset_state",
        $sformatf("wr=%b err=%b busy=%b addr=%h data=%h", bus.o_Wr_En, bus.o_Frame_Err, bus.o_Busy, bus.o_Wr_Addr, bus.o_Wr_Data),
        "all zero");

    // Good frame, then bad checksum, then leading garbage.
    send(8'hA5, 0); send(8'h10, 0); send(8'h3C, 0); send(8'h2C, 2);
    send(8'hA5, 1); send(8'h10, 0); send(8'h3C, 3); send(8'hFF, 2);
    send(8'h00, 0); send(8'hFF, 0); send(8'hA5, 0); send(8'h01, 0);
    send(8'h02, 0); send(8'h03, 3);
    // Timeout after ADDR, then a normal frame.
    send(8'hA5, 0); send(8'h10, 60);
    send(8'hA5, 0); send(8'h20, 0); send(8'h30, 0); send(8'h10, 3);
    // Gap of exactly TO idle cycles: the byte arrives on the expiry cycle and wins.
    send(8'hA5, TO); send(8'h11, TO); send(8'h22, TO); send(8'h33, TO); idle(2);
    // Gap of TO+1 idle cycles times out.
    send(8'hA5, 0); send(8'h44, TO + 1); idle(2);
    // SYNC value as payload, back-to-back frames.
    send(8'hA5, 0); send(8'hA5, 0); send(8'hA5, 0); send(8'h00, 0);
    send(8'hA5, 0); send(8'h5A, 0); send(8'h0F, 0); send(8'h55, 3);
    // Reset mid-frame drops it; following bytes land in IDLE.
    send(8'hA5, 0); send(8'h10, 1);
    step(1'b0, 8'h00, 1'b1); step(1'b0, 8'h00, 1'b1);
    send(8'h3C, 0); send(8'h2C, 3);

    for (int f = 0; f < 300; f++) begin
      logic [7:0] a, d, c;
      a = 8'($urandom); d = 8'($urandom);
      c = ($urandom_range(0, 3) != 0) ? (a ^ d) : 8'($urandom);
      if ($urandom_range(0, 7) == 0) send(8'($urandom), $urandom_range(0, 2));
      for (int k = 0; k < NB; k++) begin
        logic [7:0] b;
        int g;
        b = (k == 0) ? 8'hA5 : (k == 1) ? a : (k == 2) ? d : c;
        g = ($urandom_range(0, 99) < 92) ? $urandom_range(0, 3) : $urandom_range(TO - 2, TO + 3);
        send(b, g);
        if ($urandom_range(0, 59) == 0) begin
          repeat ($urandom_range(1, 2)) step(1'b0, 8'h00, 1'b1);
        end
      end
    end

    idle(TO + 10);
    checks++;
    if (exp_q.size() != 0)
      fail_line("drain", $sformatf("%0d events outstanding", exp_q.size()), "0");
    checks++;
    if (bus.o_Busy !== 1'b0)
      fail_line("final_busy", $sformatf("%b", bus.o_Busy), "0");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
